// File: rtl/rom_loader_pkg.sv
// Shared types and constants for the Hack program loader and its instruction ROM.
package rom_loader_pkg;

  localparam int WORD_WIDTH = 16;
  localparam int LEN_WIDTH  = 16;

  typedef enum logic [2:0] {
    S_LEN_HI  = 3'd0,
    S_LEN_LO  = 3'd1,
    S_WORD_HI = 3'd2,
    S_WORD_LO = 3'd3,
    S_RUN     = 3'd4,
    S_ERROR   = 3'd5
  } loader_state_t;

endpackage

// File: rtl/rom_n2t.sv
// Instruction ROM: one synchronous write port for the loader, one asynchronous
// read port for CPU fetch. Out-of-range reads return zero.
module rom_n2t
  import rom_loader_pkg::*;
#(
  parameter int DEPTH      = 32768,
  parameter int ADDR_WIDTH = 15
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WORD_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WORD_WIDTH-1:0] rdata
);

  localparam int IDX_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH+1)'(DEPTH);

  logic [WORD_WIDTH-1:0] mem [DEPTH];
  logic [IDX_WIDTH-1:0]  widx;
  logic [IDX_WIDTH-1:0]  ridx;
  logic                  w_in_range;
  logic                  r_in_range;

  assign widx       = waddr[IDX_WIDTH-1:0];
  assign ridx       = raddr[IDX_WIDTH-1:0];
  assign w_in_range = ({1'b0, waddr} < DEPTH_LIMIT);
  assign r_in_range = ({1'b0, raddr} < DEPTH_LIMIT);

  // NOTE: the storage array has no reset so it maps onto RAM; contents survive rst.
  always_ff @(posedge clock) begin
    if (we && w_in_range) begin
      mem[widx] <= wdata;
    end
  end

  // The read is combinational on the stored array, so a same-cycle write shows the old word.
  assign rdata = r_in_range ? mem[ridx] : '0;

endmodule

// File: rtl/rom_loader.sv
// Length-prefixed big-endian byte stream loader for the Hack instruction ROM;
// holds the CPU in reset while loading and serves rom[pc] once running.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 15,
  parameter int DEPTH      = 32768
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            byte_data,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  input  logic                  load_req,
  input  logic [ADDR_WIDTH-1:0] pc,
  output logic [WORD_WIDTH-1:0] instruction,
  output logic                  cpu_reset,
  output logic                  loading,
  output logic                  error,
  output logic [LEN_WIDTH-1:0]  words_loaded
);

  localparam logic [LEN_WIDTH:0] DEPTH_LEN = (LEN_WIDTH+1)'(DEPTH);

  loader_state_t        state;
  loader_state_t        state_next;
  logic [7:0]           len_hi;
  logic [LEN_WIDTH-1:0] len;
  logic [7:0]           word_hi;
  logic [LEN_WIDTH-1:0] len_new;
  logic [LEN_WIDTH-1:0] count_inc;
  logic                 accept;
  logic                 we;

  assign byte_ready = state inside {S_LEN_HI, S_LEN_LO, S_WORD_HI, S_WORD_LO};
  assign loading    = byte_ready;
  assign accept     = byte_valid && byte_ready;
  assign len_new    = {len_hi, byte_data};
  assign count_inc  = words_loaded + 16'd1;
  // A byte arriving together with load_req is consumed but never written.
  assign we         = accept && !load_req && (state == S_WORD_LO);

  // NOTE: default assignment first so every path drives state_next and no latch is inferred.
  always_comb begin
    state_next = state;
    if (load_req) begin
      state_next = S_LEN_HI;
    end else if (accept) begin
      case (state)
        S_LEN_HI:  state_next = S_LEN_LO;
        S_LEN_LO: begin
          if (len_new == '0)                    state_next = S_RUN;
          else if ({1'b0, len_new} > DEPTH_LEN) state_next = S_ERROR;
          else                                  state_next = S_WORD_HI;
        end
        S_WORD_HI: state_next = S_WORD_LO;
        S_WORD_LO: state_next = (count_inc == len) ? S_RUN : S_WORD_HI;
        default:   state_next = state;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= S_LEN_HI;
      len_hi       <= '0;
      len          <= '0;
      word_hi      <= '0;
      words_loaded <= '0;
      cpu_reset    <= 1'b1;
      error        <= 1'b0;
    end else begin
      state     <= state_next;
      cpu_reset <= (state_next != S_RUN);
      error     <= (state_next == S_ERROR);
      if (load_req) begin
        words_loaded <= '0;
      end else if (accept) begin
        case (state)
          S_LEN_HI:  len_hi <= byte_data;
          S_LEN_LO: begin
            len          <= len_new;
            words_loaded <= '0;
          end
          S_WORD_HI: word_hi <= byte_data;
          S_WORD_LO: words_loaded <= count_inc;
          default:   ;
        endcase
      end
    end
  end

  rom_n2t #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_rom (
    .clock (clock),
    .we    (we),
    .waddr (words_loaded[ADDR_WIDTH-1:0]),
    .wdata ({word_hi, byte_data}),
    .raddr (pc),
    .rdata (instruction)
  );

endmodule
